// File: rtl/heading_rotator.sv
// Button-driven heading rotator: left/right presses step a modular heading index on step_tick strobes.
// Optional auto-repeat while a button is held: define HEADING_ROTATOR_AUTOREPEAT_EN.
module heading_rotator #(
  parameter int STEPS_PER_QUAD = 8,
  parameter int RESET_HEADING  = 0,
  parameter int REPEAT_DELAY   = 6,
  parameter int REPEAT_DIV     = 2,
  localparam int HW = $clog2(4 * STEPS_PER_QUAD),
  localparam int QW = HW - 2
) (
  input  logic          moveClock,
  input  logic          resetn,
  input  logic          step_tick,
  input  logic          right,
  input  logic          left,
  input  logic          load,
  input  logic [HW-1:0] load_heading,
  output logic [HW-1:0] heading,
  output logic [1:0]    quadrant,
  output logic [QW-1:0] quad_step,
  output logic          turn_pulse,
  output logic          turn_dir
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] HELD_R  = 2'd1;
  localparam logic [1:0] HELD_L  = 2'd2;
  localparam logic [1:0] BLOCKED = 2'd3;

  localparam logic [HW-1:0] RESET_VAL = HW'(RESET_HEADING);
  localparam logic [HW-1:0] ONE_STEP  = {{(HW-1){1'b0}}, 1'b1};

  // Elaboration-time parameter sanity checks.
  generate
    if ((STEPS_PER_QUAD < 2) || (STEPS_PER_QUAD > 64) ||
        ((STEPS_PER_QUAD & (STEPS_PER_QUAD - 1)) != 0)) begin : g_bad_spq
      $error("heading_rotator: STEPS_PER_QUAD must be a power of two in 2..64");
    end
    if ((RESET_HEADING < 0) || (RESET_HEADING >= 4 * STEPS_PER_QUAD)) begin : g_bad_rst
      $error("heading_rotator: RESET_HEADING out of range");
    end
    if ((REPEAT_DELAY < 1) || (REPEAT_DELAY > 255) ||
        (REPEAT_DIV < 1) || (REPEAT_DIV > 255)) begin : g_bad_rep
      $error("heading_rotator: REPEAT_DELAY/REPEAT_DIV out of range");
    end
  endgenerate

  logic [1:0]    state_q, state_d;
  logic [HW-1:0] heading_q, heading_d;
  logic          pulse_q, pulse_d;
  logic          dir_q, dir_d;
  logic          hold_s;
  logic          repeat_s;

  // A held button that is still the only one pressed keeps the hold alive.
  assign hold_s = ((state_q == HELD_R) && right && !left) ||
                  ((state_q == HELD_L) && left && !right);

`ifdef HEADING_ROTATOR_AUTOREPEAT_EN
  localparam logic [8:0] FIRST_RPT = 9'(REPEAT_DELAY);
  localparam logic [8:0] NEXT_RPT  = 9'(REPEAT_DELAY + REPEAT_DIV);

  logic [8:0] cnt_q, cnt_d;
  logic [8:0] cnt_inc_s;

  assign cnt_inc_s = cnt_q + 9'd1;

  // Hold counter: fires at REPEAT_DELAY, then reloads so it fires every REPEAT_DIV ticks.
  always_comb begin
    cnt_d    = cnt_q;
    repeat_s = 1'b0;
    if (load) begin
      cnt_d = 9'd0;
    end else if (step_tick) begin
      if (hold_s) begin
        if (cnt_inc_s == FIRST_RPT) begin
          repeat_s = 1'b1;
          cnt_d    = cnt_inc_s;
        end else if (cnt_inc_s == NEXT_RPT) begin
          repeat_s = 1'b1;
          cnt_d    = FIRST_RPT;
        end else begin
          cnt_d = cnt_inc_s;
        end
      end else begin
        cnt_d = 9'd0;
      end
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Hold counter register.
  always_ff @(posedge moveClock or negedge resetn) begin
    if (!resetn) begin
      cnt_q <= 9'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`else
  assign repeat_s = 1'b0;
`endif

  // Button FSM and heading next-state; load overrides any turn.
  always_comb begin
    state_d   = state_q;
    heading_d = heading_q;
    dir_d     = dir_q;
    pulse_d   = 1'b0;
    if (load) begin
      heading_d = load_heading;
      state_d   = BLOCKED;
    end else if (step_tick) begin
      if (right && left) begin
        state_d = BLOCKED;
      end else begin
        case (state_q)
          IDLE: begin
            if (right) begin
              heading_d = heading_q + ONE_STEP;
              dir_d     = 1'b1;
              pulse_d   = 1'b1;
              state_d   = HELD_R;
            end else if (left) begin
              heading_d = heading_q - ONE_STEP;
              dir_d     = 1'b0;
              pulse_d   = 1'b1;
              state_d   = HELD_L;
            end else begin
              state_d = IDLE;
            end
          end
          HELD_R: begin
            if (!hold_s) begin
              state_d = IDLE;
            end else if (repeat_s) begin
              heading_d = heading_q + ONE_STEP;
              dir_d     = 1'b1;
              pulse_d   = 1'b1;
            end else begin
              state_d = HELD_R;
            end
          end
          HELD_L: begin
            if (!hold_s) begin
              state_d = IDLE;
            end else if (repeat_s) begin
              heading_d = heading_q - ONE_STEP;
              dir_d     = 1'b0;
              pulse_d   = 1'b1;
            end else begin
              state_d = HELD_L;
            end
          end
          BLOCKED: begin
            if (!right && !left) begin
              state_d = IDLE;
            end else begin
              state_d = BLOCKED;
            end
          end
          default: begin
            state_d = IDLE;
          end
        endcase
      end
    end else begin
      state_d = state_q;
    end
  end

  // State, heading and turn-report registers.
  always_ff @(posedge moveClock or negedge resetn) begin
    if (!resetn) begin
      state_q   <= IDLE;
      heading_q <= RESET_VAL;
      pulse_q   <= 1'b0;
      dir_q     <= 1'b1;
    end else begin
      state_q   <= state_d;
      heading_q <= heading_d;
      pulse_q   <= pulse_d;
      dir_q     <= dir_d;
    end
  end

  assign heading    = heading_q;
  assign quadrant   = heading_q[HW-1:HW-2];
  assign quad_step  = heading_q[QW-1:0];
  assign turn_pulse = pulse_q;
  assign turn_dir   = dir_q;

endmodule

// File: tb/tb_heading_rotator.sv
// Scoreboard bench for heading_rotator: a press/hold reference model queues expectations, a monitor checks them.
module tb_heading_rotator;

  localparam int STEPS = 8;
  localparam int N     = 4 * STEPS;
  localparam int HW    = 5;
  localparam int RST_H = 5;
  localparam int DLY   = 6;
  localparam int DIV   = 2;
`ifdef HEADING_ROTATOR_AUTOREPEAT_EN
  localparam bit AR = 1'b1;
`else
  localparam bit AR = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          resetn = 1'b0;
  logic          step_tick = 1'b0;
  logic          right = 1'b0;
  logic          left = 1'b0;
  logic          load = 1'b0;
  logic [HW-1:0] load_heading = '0;
  logic [HW-1:0] heading;
  logic [1:0]    quadrant;
  logic [2:0]    quad_step;
  logic          turn_pulse;
  logic          turn_dir;

  heading_rotator #(.STEPS_PER_QUAD(STEPS), .RESET_HEADING(RST_H),
                    .REPEAT_DELAY(DLY), .REPEAT_DIV(DIV)) dut (
    .moveClock(clk), .resetn(resetn), .step_tick(step_tick), .right(right),
    .left(left), .load(load), .load_heading(load_heading), .heading(heading),
    .quadrant(quadrant), .quad_step(quad_step), .turn_pulse(turn_pulse),
    .turn_dir(turn_dir));

  always #5 clk = ~clk;

  typedef struct { int head; bit pulse; bit tdir; } exp_t;
  exp_t exp_q[$];
  int tests = 0;
  int fails = 0;

  // Reference model: mode 0 = idle, 1 = holding a button, 2 = blocked.
  int m_head, m_mode, m_dir, m_hold;
  bit m_pulse, m_tdir;

  function automatic bit repeat_due(int h);
    int k;
    k = h - 1;
    return AR && (k >= DLY) && (((k - DLY) % DIV) == 0);
  endfunction

  task automatic m_move(int d);
    m_head  = (m_head + d + N) % N;
    m_pulse = 1'b1;
    m_tdir  = (d > 0);
  endtask

  task automatic model(bit rn, bit st, bit r, bit l, bit ld, int lh);
    bit pressed;
    m_pulse = 1'b0;
    if (!rn) begin
      m_head = RST_H; m_mode = 0; m_hold = 0; m_tdir = 1'b1;
    end else if (ld) begin
      m_head = lh; m_mode = 2;
    end else if (st) begin
      if (r && l) m_mode = 2;
      else if (m_mode == 2) begin
        if (!r && !l) m_mode = 0;
      end else if (m_mode == 0) begin
        if (r || l) begin
          m_dir = r ? 1 : -1; m_hold = 1; m_mode = 1; m_move(m_dir);
        end
      end else begin
        pressed = (m_dir > 0) ? r : l;
        if (!pressed) m_mode = 0;
        else begin
          m_hold++;
          if (repeat_due(m_hold)) m_move(m_dir);
        end
      end
    end
  endtask

  task automatic check(string name, int act, int req);
    tests++;
    if (act != req) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
    end
  endtask

  // One clock cycle of stimulus: drive inputs, advance the model, queue the expectation.
  task automatic cyc(bit rn, bit st, bit r, bit l, bit ld = 1'b0, int lh = 0);
    exp_t e;
    bit falling;
    falling = resetn && !rn;
    resetn = rn; step_tick = st; right = r; left = l; load = ld;
    load_heading = HW'(lh);
    model(rn, st, r, l, ld, lh);
    e.head = m_head; e.pulse = m_pulse; e.tdir = m_tdir;
    exp_q.push_back(e);
    if (falling) begin
      #1;
      check("async_reset_heading", int'(heading), RST_H);
    end
    @(negedge clk);
  endtask

  // Monitor: every cycle the DUT presents a new registered state, compare it with the oldest expectation.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        automatic exp_t e = exp_q.pop_front();
        check("heading",    int'(heading),    e.head);
        check("quadrant",   int'(quadrant),   e.head / STEPS);
        check("quad_step",  int'(quad_step),  e.head % STEPS);
        check("turn_pulse", int'(turn_pulse), int'(e.pulse));
        check("turn_dir",   int'(turn_dir),   int'(e.tdir));
      end
    end
  end

  initial begin
    bit r, l;
    int wait_cnt;
    m_head = RST_H; m_mode = 0; m_dir = 1; m_hold = 0; m_pulse = 0; m_tdir = 1;
    // Reset, then a one-tick right press from RESET_HEADING.
    cyc(0, 0, 0, 0);
    cyc(0, 1, 0, 0);
    cyc(1, 0, 0, 0);
    cyc(1, 1, 1, 0);
    cyc(1, 1, 0, 0);
    cyc(1, 0, 0, 0);
    // Wrap at both ends.
    cyc(1, 0, 0, 0, 1, 31);
    cyc(1, 1, 0, 0);
    cyc(1, 1, 1, 0);
    cyc(1, 1, 0, 0);
    cyc(1, 1, 0, 1);
    cyc(1, 1, 0, 0);
    // Both pressed, release one, release both, then a left press.
    cyc(1, 1, 1, 1);
    cyc(1, 1, 0, 1);
    cyc(1, 0, 0, 0);
    cyc(1, 1, 0, 0);
    cyc(1, 1, 0, 1);
    cyc(1, 1, 0, 0);
    // Held right for 12 ticks from heading 0.
    cyc(1, 0, 0, 0, 1, 0);
    cyc(1, 1, 0, 0);
    for (int i = 0; i < 12; i++) cyc(1, 1, 1, 0);
    check("hold12_heading", int'(heading), AR ? 4 : 1);
    cyc(1, 1, 0, 0);
    // Load during a right press; the held button must not step.
    cyc(1, 1, 1, 0, 1, 20);
    cyc(1, 1, 1, 0);
    cyc(1, 1, 1, 0);
    cyc(1, 1, 0, 0);
    cyc(1, 1, 1, 0);
    cyc(1, 1, 0, 0);
    // Reset in the middle of a right hold at heading 10.
    cyc(1, 0, 0, 0, 1, 9);
    cyc(1, 1, 0, 0);
    cyc(1, 1, 1, 0);
    cyc(1, 1, 1, 0);
    cyc(0, 1, 1, 0);
    cyc(1, 0, 1, 0);
    cyc(1, 0, 1, 0);
    cyc(1, 1, 1, 0);
    cyc(1, 1, 1, 0);
    cyc(1, 1, 0, 0);
    // Randomized traffic with sticky buttons so holds and repeats occur.
    r = 0; l = 0;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 7) == 0) r = ~r;
      if ($urandom_range(0, 9) == 0) l = ~l;
      cyc(($urandom_range(0, 99) != 0), bit'($urandom_range(0, 2) != 0), r, l,
          ($urandom_range(0, 39) == 0), int'($urandom_range(0, N - 1)));
    end
    cyc(1, 0, 0, 0);
    wait_cnt = 0;
    while (exp_q.size() > 0 && wait_cnt < 10) begin
      @(negedge clk);
      wait_cnt++;
    end
    if (exp_q.size() > 0) check("drain_timeout", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
